// File: rtl/cs_pkg.sv
// Shared definitions for the 6502 chip-select wait-state logic.
// Covers the FSM state type, select indices and the default per-select wait table.
package cs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } cs_state_e;

    localparam int SEL_RAM  = 0;
    localparam int SEL_ROM  = 1;
    localparam int SEL_ACIA = 2;
    localparam int SEL_VIA  = 3;

    // Field i (bits [i*3 +: 3]) is the PHI2 wait count for sel_n[i]: RAM 0, ROM 1, ACIA 2, VIA 0
    localparam logic [11:0] CS_WAIT_CFG_DEFAULT = {3'd0, 3'd2, 3'd1, 3'd0};

endpackage

// File: rtl/phi2_sync_edge.sv
// Brings the 6502 PHI2 clock into the clk domain through two flops.
// A third flop supplies one-clk rise and fall pulses.
module phi2_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_phi2,
    output logic o_rise,
    output logic o_fall
);

    logic r_q1;
    logic r_q2;
    logic r_q3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q1 <= 1'b0;
            r_q2 <= 1'b0;
            r_q3 <= 1'b0;
        end else begin
            r_q1 <= i_phi2;
            r_q2 <= r_q1;
            r_q3 <= r_q2;
        end
    end

    assign o_rise = r_q2 & ~r_q3;
    assign o_fall = ~r_q2 & r_q3;

endmodule

// File: rtl/cs_wait_state_gen.sv
// Holds 6502 RDY low for a per-select number of PHI2 cycles so slow devices can respond.
// Also flags decode faults and keeps a saturating count of stretched cycles.
module cs_wait_state_gen
    import cs_pkg::*;
#(
    parameter int                        N_SEL         = 4,
    parameter int                        WAIT_W        = 3,
    parameter logic [N_SEL*WAIT_W-1:0]   WAIT_CFG      = CS_WAIT_CFG_DEFAULT,
    parameter bit                        WAIT_ON_WRITE = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_phi2,
    input  logic [N_SEL-1:0] i_sel_n,
    input  logic             i_rw,
    input  logic             i_clr_err,
    output logic             o_rdy,
    output logic             o_busy,
    output logic             o_sel_err,
    output logic [15:0]      o_stretch_count
);

    logic              w_rise;
    logic              w_phi2_fall_unused;
    logic [WAIT_W-1:0] w_wait;
    logic [WAIT_W-1:0] w_field;
    logic              w_seen;
    logic              w_multi;
    logic              w_none;

    cs_state_e         r_state;
    cs_state_e         w_state_nxt;
    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_nxt;
    logic              r_rdy;
    logic              w_rdy_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [15:0]       r_stretch_count;
    logic [15:0]       w_count_nxt;

    phi2_sync_edge u_phi2_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_phi2 (i_phi2),
        .o_rise (w_rise),
        .o_fall (w_phi2_fall_unused)
    );

    // Longest wait among all active selects; a second active select marks a decode fault
    always_comb begin
        w_wait  = '0;
        w_field = '0;
        w_seen  = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < N_SEL; i++) begin
            if (!i_sel_n[i]) begin
                w_field = WAIT_CFG[i*WAIT_W +: WAIT_W];
                if (w_field > w_wait) begin
                    w_wait = w_field;
                end
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
        if (!WAIT_ON_WRITE && !i_rw) begin
            w_wait = '0;
        end
    end

    assign w_none = &i_sel_n;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_rdy           <= 1'b1;
            r_busy          <= 1'b0;
            r_err           <= 1'b0;
            r_stretch_count <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_rdy           <= w_rdy_nxt;
            r_busy          <= w_busy_nxt;
            r_err           <= w_err_nxt;
            r_stretch_count <= w_count_nxt;
        end
    end

    // Fault sets are evaluated after clr_err so a coincident fault keeps the flag set
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdy_nxt   = r_rdy;
        w_busy_nxt  = r_busy;
        w_err_nxt   = r_err;
        w_count_nxt = r_stretch_count;
        if (i_clr_err) begin
            w_err_nxt = 1'b0;
        end
        if (w_rise) begin
            if (w_multi) begin
                w_err_nxt = 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_wait != '0) begin
                        w_cnt_nxt   = w_wait;
                        w_rdy_nxt   = 1'b0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (w_none) begin
                        w_cnt_nxt   = '0;
                        w_rdy_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        if (r_stretch_count != 16'hFFFF) begin
                            w_count_nxt = r_stretch_count + 16'd1;
                        end
                        w_cnt_nxt = r_cnt - WAIT_W'(1);
                        if (r_cnt == WAIT_W'(1)) begin
                            w_rdy_nxt   = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign o_rdy           = r_rdy;
    assign o_busy          = r_busy;
    assign o_sel_err       = r_err;
    assign o_stretch_count = r_stretch_count;

endmodule

// File: tb/tb_cs_wait_state_gen.sv
// Scoreboard bench: two instances (stretch on writes / reads only) share stimulus.
// A bus-cycle reference model queues expectations; a monitor checks them at every PHI2 fall.
module tb_cs_wait_state_gen;

    typedef struct {
        int rdy[2];
        int busy[2];
        int err[2];
        int count[2];
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        phi2   = 1'b0;
    logic [3:0]  selN   = 4'b1111;
    logic        rw     = 1'b1;
    logic        clrErr = 1'b0;

    logic        rdyW, busyW, errW, rdyR, busyR, errR;
    logic [15:0] countW, countR;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nPass   = 0;

    int   cfg[4] = '{0, 1, 2, 0};
    int   mRemain[2];
    int   mErr[2];
    int   mCount[2];

    always #5 clk = ~clk;

    cs_wait_state_gen #(.WAIT_ON_WRITE(1'b1)) dutW (
        .i_clk(clk), .i_rst(rst), .i_phi2(phi2), .i_sel_n(selN), .i_rw(rw), .i_clr_err(clrErr),
        .o_rdy(rdyW), .o_busy(busyW), .o_sel_err(errW), .o_stretch_count(countW)
    );

    cs_wait_state_gen #(.WAIT_ON_WRITE(1'b0)) dutR (
        .i_clk(clk), .i_rst(rst), .i_phi2(phi2), .i_sel_n(selN), .i_rw(rw), .i_clr_err(clrErr),
        .o_rdy(rdyR), .o_busy(busyR), .o_sel_err(errR), .o_stretch_count(countR)
    );

    task automatic checkOutput(input string name, input int act, input int expv);
        nChecks++;
        if (act == expv) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    function automatic int waitFor(input logic [3:0] s, input logic r, input int k);
        int w = 0;
        for (int i = 0; i < 4; i++)
            if (!s[i] && cfg[i] > w) w = cfg[i];
        if (k == 1 && !r) w = 0;
        return w;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mRemain[k] = 0;
            mErr[k]    = 0;
            mCount[k]  = 0;
        end
    endtask

    // One bus cycle: an access either starts a stretch of W cycles or spends one pending cycle
    task automatic modelCycle(input logic [3:0] s, input logic r, input bit clrAtRise);
        int   nActive = 0;
        exp_t e;
        for (int i = 0; i < 4; i++) if (!s[i]) nActive++;
        for (int k = 0; k < 2; k++) begin
            if (clrAtRise) mErr[k] = 0;
            if (nActive > 1) mErr[k] = 1;
            if (mRemain[k] > 0) begin
                if (nActive == 0) begin
                    mRemain[k] = 0;
                    mErr[k]    = 1;
                end else begin
                    if (mCount[k] < 65535) mCount[k]++;
                    mRemain[k]--;
                end
            end else begin
                mRemain[k] = waitFor(s, r, k);
            end
            e.rdy[k]   = (mRemain[k] == 0) ? 1 : 0;
            e.busy[k]  = (mRemain[k] > 0) ? 1 : 0;
            e.err[k]   = mErr[k];
            e.count[k] = mCount[k];
        end
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic r, input bit clrAtRise);
        selN = s;
        rw   = r;
        @(negedge clk);
        phi2 = 1'b1;
        modelCycle(s, r, clrAtRise);
        @(negedge clk);
        @(negedge clk);
        clrErr = clrAtRise;
        @(negedge clk);
        clrErr = 1'b0;
        repeat (3) @(negedge clk);
        phi2 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulseClr();
        @(negedge clk);
        clrErr = 1'b1;
        @(negedge clk);
        clrErr = 1'b0;
        mErr[0] = 0;
        mErr[1] = 0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic preloadCount(input logic [15:0] v);
        @(negedge clk);
        force dutW.r_stretch_count = v;
        force dutR.r_stretch_count = v;
        @(negedge clk);
        release dutW.r_stretch_count;
        release dutR.r_stretch_count;
        mCount[0] = int'(v);
        mCount[1] = int'(v);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge phi2);
            if (expQ.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL queue: got 0 entries, expected at least 1");
            end else begin
                e = expQ.pop_front();
                checkOutput("rdyW",   int'(rdyW),   e.rdy[0]);
                checkOutput("busyW",  int'(busyW),  e.busy[0]);
                checkOutput("errW",   int'(errW),   e.err[0]);
                checkOutput("countW", int'(countW), e.count[0]);
                checkOutput("rdyR",   int'(rdyR),   e.rdy[1]);
                checkOutput("busyR",  int'(busyR),  e.busy[1]);
                checkOutput("errR",   int'(errR),   e.err[1]);
                checkOutput("countR", int'(countR), e.count[1]);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [3:0] s;
        int         pick;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] idle select, no stretch");
        repeat (5) applyStimulus(4'b1110, 1'b1, 1'b0);

        $display("[TB] two-cycle stretch, repeated");
        repeat (6) applyStimulus(4'b1011, 1'b1, 1'b0);

        $display("[TB] write vs read stretching");
        repeat (3) applyStimulus(4'b1011, 1'b0, 1'b0);
        repeat (3) applyStimulus(4'b1011, 1'b1, 1'b0);

        $display("[TB] multi-select fault and clear");
        repeat (3) applyStimulus(4'b1001, 1'b1, 1'b0);
        pulseClr();
        applyStimulus(4'b1110, 1'b1, 1'b0);
        applyStimulus(4'b1001, 1'b1, 1'b1);
        repeat (2) applyStimulus(4'b1001, 1'b1, 1'b0);

        $display("[TB] select dropped mid-wait");
        applyStimulus(4'b1011, 1'b1, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b0);

        $display("[TB] reset mid-wait and count saturation");
        applyStimulus(4'b1011, 1'b1, 1'b0);
        pulseReset();
        applyStimulus(4'b1111, 1'b1, 1'b0);
        preloadCount(16'hFFFD);
        repeat (6) applyStimulus(4'b1011, 1'b1, 1'b0);
        pulseReset();

        $display("[TB] randomized bus cycles");
        for (int n = 0; n < 80; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 2)      s = 4'b1111;
            else if (pick < 7) s = 4'b1111 ^ (4'b0001 << $urandom_range(0, 3));
            else               s = 4'($urandom_range(0, 15));
            applyStimulus(s, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 9) == 0) pulseClr();
            if ($urandom_range(0, 29) == 0) pulseReset();
        end

        repeat (5) @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
